// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with private HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             AbortE,
    input  logic             HiWriteE,
    input  logic             LoWriteE,
    input  logic [WIDTH-1:0] MtDataE,
    output logic             BusyE,
    output logic             DoneE,
    output logic             DivZeroE,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q;
    logic [DW-1:0]    acc_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic             div_q, res_neg_q, a_neg_q;

    logic load, step, fix, mt_en;

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        mt_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (StartE) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end else begin
                    mt_en = 1'b1;
                end
            end
            S_RUN: begin
                if (AbortE) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                fix     = ~AbortE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    assign BusyE = (state_q != S_IDLE);

    // Operand capture: signed ops take magnitudes, remember signs for FIX
    logic             is_signed, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;

    always_comb begin
        is_signed = ~OpE[0];
        a_neg_in  = is_signed & SrcAE[WIDTH-1];
        b_neg_in  = is_signed & SrcBE[WIDTH-1];
        mag_a_in  = a_neg_in ? WIDTH'(WIDTH'(0) - SrcAE) : SrcAE;
        mag_b_in  = b_neg_in ? WIDTH'(WIDTH'(0) - SrcBE) : SrcBE;
    end

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0] add_in, div_rem;
    logic [XW-1:0]    mul_sum, div_sh;
    logic             div_ge;
    logic [DW-1:0]    mul_next, div_next;

    always_comb begin
        add_in   = acc_q[0] ? mag_a_q : '0;
        mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, add_in};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh   = acc_q[DW-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, mag_b_q});
        div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, mag_b_q}) : div_sh[WIDTH-1:0];
        div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    // Sign fix-up and divide-by-zero override
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, raw_a, fix_hi, fix_lo;
    logic             div_zero;

    always_comb begin
        prod     = res_neg_q ? DW'(DW'(0) - acc_q) : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[DW-1:WIDTH];
        raw_a    = a_neg_q ? WIDTH'(WIDTH'(0) - mag_a_q) : mag_a_q;
        div_zero = div_q & (mag_b_q == '0);
        if (!div_q) begin
            fix_hi = prod[DW-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            fix_hi = raw_a;
            fix_lo = '1;
        end else begin
            fix_hi = a_neg_q ? WIDTH'(WIDTH'(0) - rem) : rem;
            fix_lo = res_neg_q ? WIDTH'(WIDTH'(0) - quo) : quo;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            div_q     <= 1'b0;
            res_neg_q <= 1'b0;
            a_neg_q   <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
            DoneE     <= 1'b0;
            DivZeroE  <= 1'b0;
        end else begin
            DoneE    <= fix;
            DivZeroE <= fix & div_zero;
            if (load) begin
                cnt_q     <= '0;
                mag_a_q   <= mag_a_in;
                mag_b_q   <= mag_b_in;
                div_q     <= OpE[1];
                res_neg_q <= a_neg_in ^ b_neg_in;
                a_neg_q   <= a_neg_in;
                acc_q     <= {{WIDTH{1'b0}}, OpE[1] ? mag_a_in : mag_b_in};
            end
            if (step) begin
                acc_q <= div_q ? div_next : mul_next;
                cnt_q <= cnt_q + CNTW'(1);
            end
            if (fix) begin
                HiOut <= fix_hi;
                LoOut <= fix_lo;
            end
            if (mt_en && HiWriteE) HiOut <= MtDataE;
            if (mt_en && LoWriteE) LoOut <= MtDataE;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, reference model, scoreboard queue,
// plus hand sequences for abort, MT writes, mid-run reset and an 8-bit instance.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        res_t        e;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        StartE, AbortE, HiWriteE, LoWriteE;
    logic [1:0]  OpE;
    logic [31:0] SrcAE, SrcBE, MtDataE;
    logic        BusyE, DoneE, DivZeroE;
    logic [31:0] HiOut, LoOut;

    logic        s8_start;
    logic [1:0]  s8_op;
    logic [7:0]  s8_a, s8_b;
    logic        s8_busy, s8_done, s8_dz;
    logic [7:0]  s8_hi, s8_lo;

    int checks   = 0;
    int failures = 0;
    res_t sb[$];
    logic [31:0] cur_hi, cur_lo;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
        .AbortE(AbortE), .HiWriteE(HiWriteE), .LoWriteE(LoWriteE), .MtDataE(MtDataE),
        .BusyE(BusyE), .DoneE(DoneE), .DivZeroE(DivZeroE), .HiOut(HiOut), .LoOut(LoOut)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .StartE(s8_start), .OpE(s8_op), .SrcAE(s8_a), .SrcBE(s8_b),
        .AbortE(1'b0), .HiWriteE(1'b0), .LoWriteE(1'b0), .MtDataE(8'h00),
        .BusyE(s8_busy), .DoneE(s8_done), .DivZeroE(s8_dz), .HiOut(s8_hi), .LoOut(s8_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Independent reference using native 64-bit / int arithmetic
    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      ps;
        logic [63:0] pu;
        int          sa, sb_i;
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (op)
            2'd0: begin
                ps   = longint'($signed(a)) * longint'($signed(b));
                pu   = ps;
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            2'd1: begin
                pu   = {32'h0, a} * {32'h0, b};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    r.dz = 1'b1;
                    r.hi = a;
                    r.lo = 32'hFFFFFFFF;
                end else if (op == 2'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    r.hi = 32'h0;
                    r.lo = 32'h80000000;
                end else if (op == 2'd2) begin
                    sa   = $signed(a);
                    sb_i = $signed(b);
                    r.lo = 32'(sa / sb_i);
                    r.hi = 32'(sa % sb_i);
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Issue one op, push expectation, check busy length/hold/ignored inputs, pop on DoneE
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input res_t e, input bit ab);
        int   busy;
        res_t x;
        sb.push_back(e);
        @(negedge clk);
        StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; AbortE = ab;
        @(negedge clk);
        StartE = 1'b0; AbortE = 1'b0;
        SrcAE = $urandom; SrcBE = $urandom;
        busy = 0;
        while (BusyE === 1'b1 && busy < 100) begin
            busy++;
            HiWriteE = (busy == 2);
            LoWriteE = (busy == 2);
            MtDataE  = 32'hDEADBEEF;
            StartE   = (busy == 4);
            if (busy == 16) begin
                chk("hold_hi", HiOut, cur_hi);
                chk("hold_lo", LoOut, cur_lo);
                chk("no_early_done", DoneE, 0);
            end
            @(negedge clk);
        end
        HiWriteE = 1'b0; LoWriteE = 1'b0; StartE = 1'b0;
        chk("busy_cycles", busy, 33);
        chk("done", DoneE, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            x = sb.pop_front();
            chk("hi", HiOut, x.hi);
            chk("lo", LoOut, x.lo);
            chk("divzero", DivZeroE, x.dz);
            cur_hi = x.hi;
            cur_lo = x.lo;
        end
        @(negedge clk);
        chk("done_pulse", DoneE, 0);
        chk("divzero_pulse", DivZeroE, 0);
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo);
        int busy;
        @(negedge clk);
        s8_start = 1'b1; s8_op = op; s8_a = a; s8_b = b;
        @(negedge clk);
        s8_start = 1'b0;
        busy = 0;
        while (s8_busy === 1'b1 && busy < 50) begin
            busy++;
            @(negedge clk);
        end
        chk("w8_busy", busy, 9);
        chk("w8_done", s8_done, 1);
        chk("w8_hi", s8_hi, ehi);
        chk("w8_lo", s8_lo, elo);
    endtask

    vec_t vecs[10];

    initial begin
        int   dcount;
        res_t e;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'd7,        '{32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}};
        vecs[1] = '{2'd3, 32'd100,      32'd7,        '{32'd2,        32'd14,       1'b0}};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        '{32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, '{32'h0,        32'h80000000, 1'b0}};
        vecs[4] = '{2'd3, 32'd5,        32'd0,        '{32'd5,        32'hFFFFFFFF, 1'b1}};
        vecs[5] = '{2'd2, 32'd7,        32'hFFFFFFFE, '{32'd1,        32'hFFFFFFFD, 1'b0}};
        vecs[6] = '{2'd2, 32'hFFFFFFFB, 32'd0,        '{32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1}};
        vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, '{32'h40000000, 32'h0,        1'b0}};
        vecs[8] = '{2'd0, 32'd0,        32'h12345678, '{32'h0,        32'h0,        1'b0}};
        vecs[9] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001, 1'b0}};

        reset = 1'b1;
        StartE = 1'b0; AbortE = 1'b0; HiWriteE = 1'b0; LoWriteE = 1'b0;
        OpE = 2'd0; SrcAE = '0; SrcBE = '0; MtDataE = '0;
        s8_start = 1'b0; s8_op = 2'd0; s8_a = '0; s8_b = '0;
        cur_hi = '0; cur_lo = '0;
        #3;
        chk("rst_busy", BusyE, 0);
        chk("rst_done", DoneE, 0);
        chk("rst_dz", DivZeroE, 0);
        chk("rst_hi", HiOut, 0);
        chk("rst_lo", LoOut, 0);
        @(negedge clk);
        reset = 1'b0;

        // Table vectors; vector 1 also raises AbortE alongside StartE in IDLE
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, i == 1);

        // Reset mid-run clears immediately, without a clock edge
        @(negedge clk);
        StartE = 1'b1; OpE = 2'd1; SrcAE = 32'd9; SrcBE = 32'd9;
        @(negedge clk);
        StartE = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", BusyE, 0);
        chk("midrst_hi", HiOut, 0);
        chk("midrst_lo", LoOut, 0);
        @(negedge clk);
        reset = 1'b0;
        cur_hi = '0; cur_lo = '0;

        // MTHI, then start with MTLO (dropped), abort at RUN cycle 10
        @(negedge clk);
        HiWriteE = 1'b1; MtDataE = 32'h1234;
        @(negedge clk);
        HiWriteE = 1'b0;
        cur_hi = 32'h1234;
        chk("mthi", HiOut, 32'h1234);
        chk("mthi_lo_keep", LoOut, cur_lo);
        @(negedge clk);
        StartE = 1'b1; OpE = 2'd1; SrcAE = 32'd2; SrcBE = 32'd3;
        LoWriteE = 1'b1; MtDataE = 32'hAAAA5555;
        @(negedge clk);
        StartE = 1'b0; LoWriteE = 1'b0;
        chk("abort_started", BusyE, 1);
        chk("start_beats_mtlo", LoOut, cur_lo);
        repeat (9) @(negedge clk);
        AbortE = 1'b1;
        @(negedge clk);
        AbortE = 1'b0;
        chk("abort_busy", BusyE, 0);
        chk("abort_hi", HiOut, 32'h1234);
        chk("abort_lo", LoOut, cur_lo);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (DoneE === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);
        e = '{32'h0, 32'd6, 1'b0};
        run_op(2'd1, 32'd2, 32'd3, e, 1'b0);

        // MTLO alone in IDLE
        @(negedge clk);
        LoWriteE = 1'b1; MtDataE = 32'h0BADF00D;
        @(negedge clk);
        LoWriteE = 1'b0;
        cur_lo = 32'h0BADF00D;
        chk("mtlo", LoOut, 32'h0BADF00D);
        chk("mtlo_hi_keep", HiOut, cur_hi);

        // Random operands against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        // 8-bit instance
        run8(2'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8(2'd0, 8'h80, 8'h80, 8'h40, 8'h00);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core, placed beside the ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU over WIDTH operand bits and writes results into private HI/LO registers.
- Drives a busy signal the hazard unit uses to stall MFHI/MFLO and new mult/div ops.
- Supports MTHI/MTLO writes and an abort input for pipeline flushes.

Parameters:
- WIDTH, 32, operand and HI/LO width. Legal values: 4..64.
- CNTW, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- StartE  in  1  start request, sampled at the rising edge.
- OpE  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcAE  in  WIDTH  multiplicand / dividend.
- SrcBE  in  WIDTH  multiplier / divisor.
- AbortE  in  1  cancels the in-flight operation.
- HiWriteE  in  1  MTHI write strobe.
- LoWriteE  in  1  MTLO write strobe.
- MtDataE  in  WIDTH  MTHI/MTLO data.
- BusyE  out  1  operation in flight; hazard unit stalls on this.
- DoneE  out  1  one-cycle pulse: HI/LO just updated by an operation.
- DivZeroE  out  1  pulse with DoneE when a DIV/DIVU had divisor 0.
- HiOut  out  WIDTH  HI register.
- LoOut  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): state IDLE, HI=0, LO=0, BusyE=0, DoneE=0, DivZeroE=0, counter=0, operand registers cleared.
- States:
  - IDLE -> RUN when StartE=1 at an edge. At that edge, capture magnitudes of SrcAE/SrcBE (signed ops take absolute value; unsigned ops pass through), latch the op, the sign of the result, and the dividend sign. Counter=0.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract.
    - Counter increments each step; after WIDTH steps -> FIX.
  - FIX: one cycle. Applies two's-complement negation where required, writes HI/LO, pulses DoneE (and DivZeroE if applicable), then -> IDLE.
- BusyE = (state != IDLE), combinational from the state register.
- Latency: start accepted at edge 0; HI/LO updated at edge WIDTH+1. BusyE is high for exactly WIDTH+1 cycles. DoneE is high in the cycle after edge WIDTH+1.
- Result rules:
  - Multiply: {HI,LO} = full 2*WIDTH product. Signed product is negated iff operand signs differ.
  - Divide: LO = quotient, HI = remainder. Quotient is negative iff signs differ. Remainder takes the sign of the dividend.
  - Divide by zero: no iteration short-cut; latency is unchanged. Result LO = all ones, HI = SrcAE as captured (raw). DivZeroE pulses.
  - Signed most-negative / -1: LO = most-negative value (wraps), HI = 0. No flag.
- StartE while BusyE=1 is ignored; the hazard unit guarantees this does not occur. Operands are not re-captured.
- AbortE=1 in RUN or FIX: -> IDLE at that edge. HI/LO are unchanged; no DoneE. If StartE=1 in the same cycle, abort wins and the start is dropped.
- AbortE in IDLE has no effect. An abort coinciding with a start does not cancel the start: the new op is accepted.
- MTHI/MTLO:
  - Applied at the edge only in IDLE with StartE=0. HiWriteE and LoWriteE may both be set; both registers then take MtDataE.
  - Dropped when Busy.
  - When StartE=1 in the same cycle, the start wins and the write is dropped.
- HiOut/LoOut are the registered values. They hold their old values throughout RUN and change only at FIX or on an MT write.
- Reset mid-operation: returns to IDLE immediately with HI/LO=0.

Test Plan:
- WIDTH=32, MULT SrcA=0xFFFFFFFD (-3), SrcB=7 -> BusyE high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; DoneE single pulse.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> after 33 busy cycles LO=0xFFFFFFFF, HI=5; DivZeroE pulses with DoneE.
- MTHI 0x1234 then MULTU 2*3; AbortE asserted at RUN cycle 10 -> BusyE drops next cycle, HI stays 0x1234, no DoneE. Next MULTU 2*3 -> HI=0, LO=6.
- Assert reset mid-RUN -> BusyE=0 and HI=LO=0 immediately, without waiting for a clock. StartE and MTLO in the same IDLE cycle -> MTLO dropped.
- WIDTH=8: MULTU 255*255 -> HI=0xFE, LO=0x01, BusyE 9 cycles. MULT 0x80*0x80 -> HI=0x40, LO=0x00.
